// File: rtl/fifo_sync.sv
// Single-clock FIFO controller driving one ram_2port; pointers, occupancy and registered flags.
// Optional almost-full/almost-empty flags are enabled by defining FIFO_ALMOST_FLAGS_EN.

module ram_2port #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 256
) (
   input  logic                     i_rst,
   input  logic                     i_wr_clk,
   input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  logic                     i_wr_dv,
   input  logic [WIDTH-1:0]         i_wr_data,
   input  logic                     i_rd_clk,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   input  logic                     i_rd_en,
   output logic                     o_rd_dv,
   output logic [WIDTH-1:0]         o_rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge i_wr_clk) begin
      if (i_wr_dv) mem[i_wr_addr] <= i_wr_data;
   end

   // Data path is not reset; only the valid strobe is, so a reset kills an in-flight read.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_en) o_rd_data <= mem[i_rd_addr];
   end

   always_ff @(posedge i_rd_clk or posedge i_rst) begin
      if (i_rst) o_rd_dv <= 1'b0;
      else       o_rd_dv <= i_rd_en;
   end
endmodule

module fifo_sync #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 256,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_dv,
   input  logic [WIDTH-1:0]         i_wr_data,
   output logic                     o_full,
   input  logic                     i_rd_en,
   output logic                     o_rd_dv,
   output logic [WIDTH-1:0]         o_rd_data,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_af,
   output logic                     o_ae
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
      $error("fifo_sync: DEPTH must be a power of 2 and >= 4");
   end

   if (AE_LEVEL >= AF_LEVEL) begin : g_level_chk
      $error("fifo_sync: AE_LEVEL must be below AF_LEVEL");
   end

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_nxt;
   logic          empty_q, full_q;
   logic          wr_acc, rd_acc;

   assign wr_acc = i_wr_dv & ~full_q;
   assign rd_acc = i_rd_en & ~empty_q;

   always_comb begin
      count_nxt = count;
      case ({wr_acc, rd_acc})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         count   <= count_nxt;
         empty_q <= (count_nxt == '0);
         full_q  <= (count_nxt == CW'(DEPTH));
      end
   end

`ifdef FIFO_ALMOST_FLAGS_EN
   logic af_q, ae_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (count_nxt >= CW'(AF_LEVEL));
         ae_q <= (count_nxt <= CW'(AE_LEVEL));
      end
   end

   assign o_af = af_q;
   assign o_ae = ae_q;
`else
   assign o_af = 1'b0;
   assign o_ae = 1'b1;
`endif

   assign o_full  = full_q;
   assign o_empty = empty_q;
   assign o_count = count;

   ram_2port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_rst     (i_rst),
      .i_wr_clk  (i_clk),
      .i_wr_addr (wr_ptr),
      .i_wr_dv   (wr_acc),
      .i_wr_data (i_wr_data),
      .i_rd_clk  (i_clk),
      .i_rd_addr (rd_ptr),
      .i_rd_en   (rd_acc),
      .o_rd_dv   (o_rd_dv),
      .o_rd_data (o_rd_data)
   );
endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: directed vector table, corner-case sequences and random traffic
// compared against a queue-based occupancy model.

module tb_fifo_sync;
   localparam int WIDTH = 16;
   localparam int DEPTH = 256;
   localparam int AF    = DEPTH - 4;
   localparam int AE    = 4;

   logic             i_clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_wr_dv = 1'b0;
   logic [WIDTH-1:0] i_wr_data = '0;
   logic             i_rd_en = 1'b0;
   logic             o_full, o_rd_dv, o_empty, o_af, o_ae;
   logic [WIDTH-1:0] o_rd_data;
   logic [8:0]       o_count;

   int n_cmp = 0;
   int n_err = 0;
   logic [WIDTH-1:0] q[$];

   always #5 i_clk = ~i_clk;

   fifo_sync #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_wr_dv   (i_wr_dv),
      .i_wr_data (i_wr_data),
      .o_full    (o_full),
      .i_rd_en   (i_rd_en),
      .o_rd_dv   (o_rd_dv),
      .o_rd_data (o_rd_data),
      .o_empty   (o_empty),
      .o_count   (o_count),
      .o_af      (o_af),
      .o_ae      (o_ae)
   );

   typedef struct {
      logic             wr;
      logic             rd;
      logic [WIDTH-1:0] d;
      int               cnt;
      logic             emp;
      logic             dv;
      logic [WIDTH-1:0] rdat;
   } vec_t;

   vec_t tbl[16];

   function automatic vec_t mk(input logic wr, input logic rd, input logic [WIDTH-1:0] d,
                               input int cnt, input logic emp, input logic dv,
                               input logic [WIDTH-1:0] rdat);
      vec_t v;
      v.wr = wr; v.rd = rd; v.d = d; v.cnt = cnt; v.emp = emp; v.dv = dv; v.rdat = rdat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One clock of traffic; expectations come from the queue model, checked #1 after the edge.
   task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
      logic             wa, ra;
      logic [WIDTH-1:0] ed;
      wa = wr && (q.size() < DEPTH);
      ra = rd && (q.size() != 0);
      ed = '0;
      if (ra) ed = q.pop_front();
      if (wa) q.push_back(d);
      i_wr_dv = wr; i_rd_en = rd; i_wr_data = d;
      @(posedge i_clk); #1;
      chk("rd_dv", 32'(o_rd_dv), 32'(ra));
      if (ra) chk("rd_data", 32'(o_rd_data), 32'(ed));
      chk("count", 32'(o_count), 32'(q.size()));
      chk("empty", 32'(o_empty), 32'(q.size() == 0));
      chk("full", 32'(o_full), 32'(q.size() == DEPTH));
`ifdef FIFO_ALMOST_FLAGS_EN
      chk("af", 32'(o_af), 32'(q.size() >= AF));
      chk("ae", 32'(o_ae), 32'(q.size() <= AE));
`else
      chk("af_tied", 32'(o_af), 32'd0);
      chk("ae_tied", 32'(o_ae), 32'd1);
`endif
      i_wr_dv = 1'b0; i_rd_en = 1'b0;
   endtask

   task automatic do_reset();
      i_wr_dv = 1'b0; i_rd_en = 1'b0;
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      q.delete();
      @(posedge i_clk); #1;
   endtask

   initial begin
      tbl[0]  = mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[1]  = mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[2]  = mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[3]  = mk(1, 0, 16'h0001, 1, 0, 0, 16'h0000);
      tbl[4]  = mk(1, 0, 16'h0002, 2, 0, 0, 16'h0000);
      tbl[5]  = mk(1, 0, 16'h0003, 3, 0, 0, 16'h0000);
      tbl[6]  = mk(1, 0, 16'h0004, 4, 0, 0, 16'h0000);
      tbl[7]  = mk(0, 1, 16'h0000, 3, 0, 1, 16'h0001);
      tbl[8]  = mk(0, 1, 16'h0000, 2, 0, 1, 16'h0002);
      tbl[9]  = mk(0, 1, 16'h0000, 1, 0, 1, 16'h0003);
      tbl[10] = mk(0, 1, 16'h0000, 0, 1, 1, 16'h0004);
      tbl[11] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[12] = mk(1, 1, 16'h0055, 1, 0, 0, 16'h0000);
      tbl[13] = mk(0, 1, 16'h0000, 0, 1, 1, 16'h0055);
      tbl[14] = mk(0, 1, 16'h0000, 0, 1, 0, 16'h0000);
      tbl[15] = mk(0, 0, 16'h0000, 0, 1, 0, 16'h0000);

      do_reset();
      chk("rst_empty", 32'(o_empty), 32'd1);
      chk("rst_full", 32'(o_full), 32'd0);
      chk("rst_count", 32'(o_count), 32'd0);
      chk("rst_rd_dv", 32'(o_rd_dv), 32'd0);
      chk("rst_af", 32'(o_af), 32'd0);
      chk("rst_ae", 32'(o_ae), 32'd1);

      // Directed table: idle reads, 1..4 in and out, write+read while empty.
      for (int i = 0; i < 16; i++) begin
         i_wr_dv = tbl[i].wr; i_rd_en = tbl[i].rd; i_wr_data = tbl[i].d;
         @(posedge i_clk); #1;
         chk($sformatf("tbl%0d_count", i), 32'(o_count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_empty", i), 32'(o_empty), 32'(tbl[i].emp));
         chk($sformatf("tbl%0d_full", i), 32'(o_full), 32'd0);
         chk($sformatf("tbl%0d_dv", i), 32'(o_rd_dv), 32'(tbl[i].dv));
         if (tbl[i].dv) chk($sformatf("tbl%0d_data", i), 32'(o_rd_data), 32'(tbl[i].rdat));
      end
      i_wr_dv = 1'b0; i_rd_en = 1'b0;

      // Fill to DEPTH, overflow write ignored, drain: pointer wrap and data order.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(i));
      chk("fill_full", 32'(o_full), 32'd1);
      chk("fill_count", 32'(o_count), 32'(DEPTH));
      step(1'b1, 1'b0, 16'hDEAD);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
      chk("drain_empty", 32'(o_empty), 32'd1);

      // Simultaneous write+read while full: read wins, write dropped.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, WIDTH'(16'h1000 + i));
      step(1'b1, 1'b1, 16'hBEEF);
      chk("fullwr_count", 32'(o_count), 32'(DEPTH - 1));
      chk("fullwr_full", 32'(o_full), 32'd0);
      while (q.size() != 0) step(1'b0, 1'b1, '0);

      // Steady state at count 10 for 600 cycles.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, WIDTH'(16'h2000 + i));
      for (int i = 0; i < 600; i++) step(1'b1, 1'b1, WIDTH'(16'h2000 + 10 + i));
      chk("steady_count", 32'(o_count), 32'd10);
      while (q.size() != 0) step(1'b0, 1'b1, '0);

      // Random traffic in phases biased toward filling, then toward draining.
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 400; i++) begin
            int pw;
            pw = (ph % 2 == 0) ? 80 : 25;
            step(($urandom_range(99) < pw), ($urandom_range(99) < 100 - pw),
                 WIDTH'($urandom));
         end
      end

      // Asynchronous reset mid-stream with a read in flight.
      do_reset();
      for (int i = 0; i < 51; i++) step(1'b1, 1'b0, WIDTH'(16'h3000 + i));
      step(1'b0, 1'b1, '0);
      chk("pre_rst_count", 32'(o_count), 32'd50);
      #2 i_rst = 1'b1;
      #1;
      chk("async_rst_dv", 32'(o_rd_dv), 32'd0);
      chk("async_rst_count", 32'(o_count), 32'd0);
      chk("async_rst_empty", 32'(o_empty), 32'd1);
      q.delete();
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, WIDTH'(16'h4000 + i));
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
